// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit and the APB register
// block that drives its op select from the arith_sel field.
package arith_pkg;

    // Op encodings; the register block decodes arith_sel with these same values.
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // True when an accepted op needs the iterative datapath. Divide by zero
    // is resolved in a single cycle, so it never enters CALC.
    function automatic logic needs_iter(input logic [1:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/arith_iter_core.sv
// Iteration registers and per-cycle step logic for shift-add multiply and
// restoring divide. The top FSM loads operands and issues one step per cycle;
// res_o is the result after the step currently being applied, so the top can
// capture the final result on the same edge that performs the last step.
module arith_iter_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] res_o
);

    logic               div_q;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic [WIDTH:0]     rem_q,   rem_d;
    logic [WIDTH-1:0]   quo_q,   quo_d;
    logic [WIDTH-1:0]   dvsr_q;

    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   trial;

    // One multiply step and one divide step, computed from current state.
    always_comb begin
        acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;

        // Dividend bits shift out of quo_q's MSB into the partial remainder
        // while quotient bits shift in at the LSB. The extra top bit gives a
        // clean borrow for the trial subtract.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {2'b00, dvsr_q};
        if (trial[WIDTH+1]) begin
            rem_d = shifted[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end

        // Final remainder is always below the divisor, so WIDTH bits suffice.
        res_o = div_q ? {rem_d[WIDTH-1:0], quo_d} : acc_d;
    end

    // Operand load on accept, then one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
        end else if (load_i) begin
            div_q   <= div_i;
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_i};
            mplr_q  <= b_i;
            rem_q   <= '0;
            quo_q   <= a_i;
            dvsr_q  <= b_i;
        end else if (step_i) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

endmodule

// File: rtl/arith_op_seq.sv
// Sequential arithmetic unit: add/sub/div-by-zero finish in one cycle,
// mul/div iterate WIDTH cycles in arith_iter_core. Start/busy/done handshake;
// out/err hold until the next completed operation.
module arith_op_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   in1_i,
    input  logic [WIDTH-1:0]   in2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] out_o,
    output logic               err_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] out_q,   out_d;
    logic               err_q,   err_d;
    logic               done_q,  done_d;

    logic               core_load;
    logic               core_step;
    logic [2*WIDTH-1:0] core_res;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] sc_out;
    logic               sc_err;

    arith_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (core_load),
        .step_i (core_step),
        .div_i  (op_i == OP_DIV),
        .a_i    (in1_i),
        .b_i    (in2_i),
        .res_o  (core_res)
    );

    // Single-cycle result for add, sub and divide by zero.
    always_comb begin
        sum    = {1'b0, in1_i} + {1'b0, in2_i};
        sc_out = '0;
        sc_err = 1'b0;
        case (op_i)
            OP_ADD: sc_out[WIDTH:0] = sum;
            OP_SUB: begin
                if (in1_i >= in2_i) begin
                    sc_out[WIDTH-1:0] = in1_i - in2_i;
                end else begin
                    sc_out = '1;
                    sc_err = 1'b1;
                end
            end
            default: begin
                sc_out = '1;
                sc_err = 1'b1;
            end
        endcase
    end

    // FSM next state, counter and result capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        err_d     = err_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (needs_iter(op_i, in2_i == '0)) begin
                        core_load = 1'b1;
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = CALC;
                    end else begin
                        out_d  = sc_out;
                        err_d  = sc_err;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = core_res;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = done_q;
    assign out_o  = out_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_arith_op_seq.sv
// Directed bench for arith_op_seq at WIDTH=8. Inputs are driven on the falling
// edge; outputs are sampled on the falling edge. Sample 1 is the falling edge
// right after the accept edge, so single-cycle ops show done at sample 1 and
// iterative ops at sample WIDTH+1.
module tb_arith_op_seq;
    import arith_pkg::*;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   in1;
    logic [W-1:0]   in2;
    logic           busy;
    logic           done;
    logic [2*W-1:0] out;
    logic           err;

    int total  = 0;
    int passed = 0;
    int n, nb, pulses;

    arith_op_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .op_i    (op),
        .in1_i   (in1),
        .in2_i   (in2),
        .busy_o  (busy),
        .done_o  (done),
        .out_o   (out),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request for one cycle (or leave start high when hold=1);
    // returns at sample 1.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Bounded wait for done; n is the sample index where done was seen,
    // nb the number of samples with busy high before it.
    task automatic wait_done(output int n_o, output int nb_o);
        n_o  = 1;
        nb_o = 0;
        while (!done && n_o < 64) begin
            if (busy) nb_o++;
            @(negedge clk);
            n_o++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_n, input int exp_busy,
                          input logic [2*W-1:0] exp_out, input logic exp_err);
        int ln, lb;
        issue(o, a, b, 1'b0);
        wait_done(ln, lb);
        check({tag, " latency"}, 32'(ln), 32'(exp_n));
        check({tag, " busy"},    32'(lb), 32'(exp_busy));
        check({tag, " out"},     32'(out), 32'(exp_out));
        check({tag, " err"},     32'(err), 32'(exp_err));
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_ADD;
        in1   = '0;
        in2   = '0;
        #1;
        check("reset out",  32'(out),  32'd0);
        check("reset err",  32'(err),  32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add 200+100", OP_ADD, 8'd200, 8'd100, 1, 0, 16'h012C, 1'b0);
        run_op("add 255+255", OP_ADD, 8'd255, 8'd255, 1, 0, 16'h01FE, 1'b0);
        run_op("sub 5-9",     OP_SUB, 8'd5,   8'd9,   1, 0, 16'hFFFF, 1'b1);
        run_op("sub 9-5",     OP_SUB, 8'd9,   8'd5,   1, 0, 16'h0004, 1'b0);
        run_op("sub 7-7",     OP_SUB, 8'd7,   8'd7,   1, 0, 16'h0000, 1'b0);
        run_op("mul 255*255", OP_MUL, 8'd255, 8'd255, 9, 8, 16'hFE01, 1'b0);
        run_op("mul 0*200",   OP_MUL, 8'd0,   8'd200, 9, 8, 16'h0000, 1'b0);
        run_op("div 100/7",   OP_DIV, 8'd100, 8'd7,   9, 8, 16'h020E, 1'b0);
        run_op("div 5/9",     OP_DIV, 8'd5,   8'd9,   9, 8, 16'h0500, 1'b0);
        run_op("div 255/1",   OP_DIV, 8'd255, 8'd1,   9, 8, 16'h00FF, 1'b0);
        run_op("div 3/0",     OP_DIV, 8'd3,   8'd0,   1, 0, 16'hFFFF, 1'b1);

        // Start pulsed with an add while a multiply is busy must be dropped.
        issue(OP_MUL, 8'd15, 8'd17, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = OP_ADD;
        in1   = 8'd1;
        in2   = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        check("ignored start latency", 32'(n + 3), 32'd9);
        check("ignored start busy",    32'(nb),    32'd5);
        check("ignored start out",     32'(out),   32'h00FF);
        @(negedge clk);
        check("ignored start no 2nd done", 32'(done), 32'd0);
        @(negedge clk);
        check("ignored start out held",    32'(out),  32'h00FF);

        // Back-to-back: start held high, second op accepted in the done cycle.
        issue(OP_MUL, 8'd3, 8'd4, 1'b1);
        wait_done(n, nb);
        check("b2b mul latency", 32'(n),   32'd9);
        check("b2b mul out",     32'(out), 32'd12);
        op  = OP_DIV;
        in1 = 8'd9;
        in2 = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b div accepted", 32'(busy), 32'd1);
        wait_done(n, nb);
        check("b2b div latency", 32'(n),   32'd9);
        check("b2b div out",     32'(out), 32'h0003);
        check("b2b div err",     32'(err), 32'd0);

        // Reset in the middle of a divide aborts it with no trailing done.
        issue(OP_DIV, 8'd100, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out",  32'(out),  32'd0);
        check("midrst err",  32'(err),  32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst no done", 32'(pulses), 32'd0);
        run_op("add 1+1 after reset", OP_ADD, 8'd1, 8'd1, 1, 0, 16'h0002, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
